// File: rtl/ifetch_ctrl.sv
// PC generation and instruction-bus control ahead of the fetch stage.
// Keeps one ibus request in flight, squashes stale responses after a redirect, and parks data during stalls.

package ifetch_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_misalign
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] pending_pc;
    logic [31:0] hold_instr;
    logic        misalign;
    logic        unused_addr_ok;

    assign misalign       = (pc[1:0] != 2'b00);
    assign unused_addr_ok = iresp.addr_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc         <= RESET_PC;
            state      <= FETCH;
            pending_pc <= '0;
            hold_instr <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (misalign) begin
                        if (redirect)
                            pc <= redirect_pc;
                        else if (!stall)
                            pc <= pc + 64'd4;
                    end else if (iresp.data_ok) begin
                        if (redirect)
                            pc <= redirect_pc;
                        else if (stall) begin
                            hold_instr <= iresp.data;
                            state      <= HOLD;
                        end else
                            pc <= pc + 64'd4;
                    end else if (redirect) begin
                        // The bus cannot abort, so wait out the stale response first.
                        pending_pc <= redirect_pc;
                        state      <= DROP;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end else if (!stall) begin
                        pc    <= pc + 64'd4;
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (iresp.data_ok) begin
                        pc    <= redirect ? redirect_pc : pending_pc;
                        state <= FETCH;
                    end else if (redirect)
                        pending_pc <= redirect_pc;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // A redirect in the same cycle always suppresses the presented instruction.
    always_comb begin
        ireq.valid   = 1'b0;
        ireq.addr    = pc;
        out_valid    = 1'b0;
        out_pc       = pc;
        out_instr    = '0;
        out_misalign = misalign;
        if (reset) begin
            unique case (state)
                FETCH: begin
                    if (misalign) begin
                        out_valid = !redirect;
                    end else begin
                        ireq.valid = 1'b1;
                        out_valid  = iresp.data_ok && !redirect;
                        out_instr  = iresp.data;
                    end
                end
                HOLD: begin
                    out_valid = !redirect;
                    out_instr = hold_instr;
                end
                DROP: ireq.valid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl: a random-latency bus plus a stream-level reference model
// that tracks the next PC to deliver, any parked word and whether a stale response is owed.

module tb_ifetch_ctrl;
    import ifetch_pkg::*;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;

    always #5 clk = ~clk;

    ifetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .ireq        (ireq),
        .iresp       (iresp),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_misalign(out_misalign)
    );

    int checkCount = 0;
    int passCount  = 0;
    int acceptCount = 0;

    // Reference model of the fetch stream
    logic [63:0] nextPc;
    logic        wordParked;
    logic [31:0] parkedWord;
    logic        staleOwed;
    logic [63:0] staleTarget;

    // Bus model
    int busCnt;
    int busLat;
    int maxLat;

    function automatic logic [31:0] memWord(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h5a3c_0013;
    endfunction

    function automatic logic [63:0] randTarget(input int misPct);
        logic [63:0] base;
        logic [63:0] low;
        if ($urandom_range(0, 9) == 0)
            base = 64'hFFFF_FFFF_FFFF_FFF0;
        else
            base = 64'h0000_0000_8000_0000 + 64'($urandom_range(0, 4095)) * 64'd4;
        low = (int'($urandom_range(0, 99)) < misPct) ? 64'($urandom_range(1, 3)) : 64'd0;
        return base + low;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    endtask

    task automatic stepCycle(input logic rstN, input logic stallV, input logic redirV, input logic [63:0] tgt);
        logic        eReq;
        logic        eOut;
        logic [31:0] eInstr;
        logic        aligned;
        logic        dataOk;
        @(posedge clk);
        #1;
        reset         = rstN;
        stall         = stallV;
        redirect      = redirV;
        redirect_pc   = tgt;
        iresp.addr_ok = 1'b0;
        iresp.data_ok = 1'b0;
        iresp.data    = $urandom;
        #1;
        if (rstN && ireq.valid === 1'b1) begin
            iresp.addr_ok = 1'b1;
            if (busCnt >= busLat) begin
                iresp.data_ok = 1'b1;
                iresp.data    = memWord(ireq.addr);
            end
        end
        dataOk = iresp.data_ok;
        @(negedge clk);

        aligned = (nextPc[1:0] == 2'b00);
        eInstr  = '0;
        if (!rstN) begin
            eReq = 1'b0;
            eOut = 1'b0;
        end else if (wordParked) begin
            eReq   = 1'b0;
            eOut   = !redirV;
            eInstr = parkedWord;
        end else if (staleOwed) begin
            eReq = 1'b1;
            eOut = 1'b0;
        end else if (!aligned) begin
            eReq = 1'b0;
            eOut = !redirV;
        end else begin
            eReq   = 1'b1;
            eOut   = dataOk && !redirV;
            eInstr = memWord(nextPc);
        end

        checkOutput("ireq_valid", 64'(ireq.valid), 64'(eReq));
        if (eReq)
            checkOutput("ireq_addr", ireq.addr, nextPc);
        checkOutput("out_valid", 64'(out_valid), 64'(eOut));
        if (eOut) begin
            checkOutput("out_pc", out_pc, nextPc);
            checkOutput("out_instr", 64'(out_instr), 64'(eInstr));
        end
        if (rstN)
            checkOutput("out_misalign", 64'(out_misalign), 64'(!aligned));

        if (!rstN) begin
            nextPc      = RESET_PC;
            wordParked  = 1'b0;
            staleOwed   = 1'b0;
            staleTarget = '0;
            busCnt      = 0;
        end else begin
            if (redirV) begin
                if (eReq && !dataOk) begin
                    staleOwed   = 1'b1;
                    staleTarget = tgt;
                end else begin
                    nextPc     = tgt;
                    wordParked = 1'b0;
                    staleOwed  = 1'b0;
                end
            end else if (staleOwed) begin
                if (dataOk) begin
                    nextPc    = staleTarget;
                    staleOwed = 1'b0;
                end
            end else if (eOut && !stallV) begin
                acceptCount++;
                nextPc     = nextPc + 64'd4;
                wordParked = 1'b0;
            end else if (eReq && dataOk) begin
                wordParked = 1'b1;
                parkedWord = memWord(nextPc);
            end
            if (ireq.valid === 1'b1) begin
                if (dataOk) begin
                    busCnt = 0;
                    busLat = int'($urandom_range(0, maxLat));
                end else
                    busCnt++;
            end else
                busCnt = 0;
        end
    endtask

    task automatic applyStimulus(input int cycles, input int stallPct, input int redirPct,
                                 input int misPct, input int rstPct, input int maxLatency);
        maxLat = maxLatency;
        busLat = (busLat > maxLat) ? maxLat : busLat;
        for (int i = 0; i < cycles; i++) begin
            stepCycle(!(int'($urandom_range(0, 99)) < rstPct),
                      int'($urandom_range(0, 99)) < stallPct,
                      int'($urandom_range(0, 99)) < redirPct,
                      randTarget(misPct));
        end
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        iresp       = '0;
        nextPc      = RESET_PC;
        wordParked  = 1'b0;
        parkedWord  = '0;
        staleOwed   = 1'b0;
        staleTarget = '0;
        busCnt      = 0;
        busLat      = 1;
        maxLat      = 1;

        repeat (3) stepCycle(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(40,  0,  0,  0, 0, 1);
        applyStimulus(300, 50, 0,  0, 0, 2);
        applyStimulus(400, 20, 15, 0, 0, 2);
        applyStimulus(300, 30, 20, 40, 0, 2);
        applyStimulus(400, 30, 15, 20, 3, 2);
        applyStimulus(200, 10, 5,  0, 0, 0);

        $display("[TB] %0d instructions accepted", acceptCount);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
